// File: rtl/morse_key_decoder.sv
// Morse key decoder: synchronizes a raw key, classifies presses as dot/dash by
// duration, and emits a letter index (0=A..25=Z) or an error strobe per letter.
module morse_key_decoder #(
  parameter int UNIT_CYCLES   = 1000,
  parameter int GLITCH_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_i,
  output logic [4:0] letter_o,
  output logic       valid_o,
  output logic       error_o,
  output logic       busy_o
);

  localparam logic [CNT_W-1:0] GLITCH_LEN = CNT_W'(GLITCH_CYCLES);
  localparam logic [CNT_W-1:0] DASH_LEN   = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(3 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PRESS  = 2'd1,
    S_GAP    = 2'd2,
    S_DECODE = 2'd3
  } state_t;

  // Symbols sit in s[n-1:0], oldest in the highest used bit; returns {hit, index}.
  function automatic logic [5:0] f_decode(input logic [2:0] n, input logic [3:0] s);
    logic [5:0] res;
    res = 6'd0;
    case ({n, s})
      7'b001_0000: res = {1'b1, 5'd4};   // E .
      7'b001_0001: res = {1'b1, 5'd19};  // T -
      7'b010_0000: res = {1'b1, 5'd8};   // I ..
      7'b010_0001: res = {1'b1, 5'd0};   // A .-
      7'b010_0010: res = {1'b1, 5'd13};  // N -.
      7'b010_0011: res = {1'b1, 5'd12};  // M --
      7'b011_0000: res = {1'b1, 5'd18};  // S ...
      7'b011_0001: res = {1'b1, 5'd20};  // U ..-
      7'b011_0010: res = {1'b1, 5'd17};  // R .-.
      7'b011_0011: res = {1'b1, 5'd22};  // W .--
      7'b011_0100: res = {1'b1, 5'd3};   // D -..
      7'b011_0101: res = {1'b1, 5'd10};  // K -.-
      7'b011_0110: res = {1'b1, 5'd6};   // G --.
      7'b011_0111: res = {1'b1, 5'd14};  // O ---
      7'b100_0000: res = {1'b1, 5'd7};   // H ....
      7'b100_0001: res = {1'b1, 5'd21};  // V ...-
      7'b100_0010: res = {1'b1, 5'd5};   // F ..-.
      7'b100_0100: res = {1'b1, 5'd11};  // L .-..
      7'b100_0110: res = {1'b1, 5'd15};  // P .--.
      7'b100_0111: res = {1'b1, 5'd9};   // J .---
      7'b100_1000: res = {1'b1, 5'd1};   // B -...
      7'b100_1001: res = {1'b1, 5'd23};  // X -..-
      7'b100_1010: res = {1'b1, 5'd2};   // C -.-.
      7'b100_1011: res = {1'b1, 5'd24};  // Y -.--
      7'b100_1100: res = {1'b1, 5'd25};  // Z --..
      7'b100_1101: res = {1'b1, 5'd16};  // Q --.-
      default:     res = 6'd0;
    endcase
    return res;
  endfunction

  logic             r_sync1, r_sync2;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [2:0]       r_nsym, w_nsym_nxt;
  logic [3:0]       r_sym, w_sym_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             r_from_gap, w_from_gap_nxt;
  logic [4:0]       r_letter, w_letter_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_error, w_error_nxt;
  logic             r_busy;
  logic             w_key_s;
  logic             w_dash;
  logic [5:0]       w_dec;

  assign w_key_s   = r_sync2;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_dash    = (r_cnt >= DASH_LEN);
  assign w_dec     = f_decode(r_nsym, r_sym);

  // Next-state, symbol collection and decode result.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_nsym_nxt     = r_nsym;
    w_sym_nxt      = r_sym;
    w_ovf_nxt      = r_ovf;
    w_from_gap_nxt = r_from_gap;
    w_letter_nxt   = r_letter;
    w_valid_nxt    = 1'b0;
    w_error_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_key_s) begin
          w_state_nxt    = S_PRESS;
          w_cnt_nxt      = {{(CNT_W-1){1'b0}}, 1'b1};
          w_from_gap_nxt = 1'b0;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      S_PRESS: begin
        if (w_key_s) begin
          w_cnt_nxt = w_cnt_inc;
        end else if (r_cnt < GLITCH_LEN) begin
          w_state_nxt = r_from_gap ? S_GAP : S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          if (r_nsym == 3'd4) begin
            w_ovf_nxt = 1'b1;
          end else begin
            w_sym_nxt  = {r_sym[2:0], w_dash};
            w_nsym_nxt = r_nsym + 3'd1;
          end
          w_state_nxt = S_GAP;
          w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_GAP: begin
        if (w_key_s) begin
          w_state_nxt    = S_PRESS;
          w_cnt_nxt      = {{(CNT_W-1){1'b0}}, 1'b1};
          w_from_gap_nxt = 1'b1;
        end else if (r_cnt >= GAP_END) begin
          w_state_nxt = S_DECODE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_DECODE: begin
        if (w_dec[5] && !r_ovf) begin
          w_letter_nxt = w_dec[4:0];
          w_valid_nxt  = 1'b1;
        end else begin
          w_error_nxt = 1'b1;
        end
        w_sym_nxt      = 4'd0;
        w_nsym_nxt     = 3'd0;
        w_ovf_nxt      = 1'b0;
        w_from_gap_nxt = 1'b0;
        // A press starting during the decode cycle is counted from here.
        if (w_key_s) begin
          w_state_nxt = S_PRESS;
          w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, synchronizer, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_nsym     <= 3'd0;
      r_sym      <= 4'd0;
      r_ovf      <= 1'b0;
      r_from_gap <= 1'b0;
      r_letter   <= 5'd0;
      r_valid    <= 1'b0;
      r_error    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sync1    <= key_i;
      r_sync2    <= r_sync1;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_nsym     <= w_nsym_nxt;
      r_sym      <= w_sym_nxt;
      r_ovf      <= w_ovf_nxt;
      r_from_gap <= w_from_gap_nxt;
      r_letter   <= w_letter_nxt;
      r_valid    <= w_valid_nxt;
      r_error    <= w_error_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign letter_o = r_letter;
  assign valid_o  = r_valid;
  assign error_o  = r_error;
  assign busy_o   = r_busy;

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Upstream stage of the seven-segment letter display; feeds it a letter index (0=A … 25=Z).
- Samples a raw Morse key input, classifies each press as dot or dash by duration, and collects up to 4 symbols per letter.
- On an inter-letter gap it looks up the pattern and emits the letter index with a one-cycle valid strobe, or an error strobe if the pattern is invalid.

Parameters:
- UNIT_CYCLES, 1000, clock cycles per Morse time unit (one dot).
- GLITCH_CYCLES, 4, presses shorter than this many cycles are discarded.
- CNT_W, 16, duration counter width; must satisfy 3*UNIT_CYCLES < 2^CNT_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- key_i  in  1  raw Morse key, 1 = pressed, asynchronous to clk
- letter_o  out  5  last decoded letter index 0..25, held until the next valid decode
- valid_o  out  1  one-cycle strobe: letter_o was updated this cycle
- error_o  out  1  one-cycle strobe: the letter just ended was invalid
- busy_o  out  1  high while a letter is in progress (PRESS, or GAP with symbols pending)

Behaviour:
- Reset, rst_n=0 at a clk edge:
  - Outputs: letter_o=0, valid_o=0, error_o=0, busy_o=0.
  - Internal: state=IDLE, sync flops=0, counters=0, symbol count=0, shift register=0, overflow=0.
- Synchronizer: key_i passes through 2 flops to give key_s. All timing is measured on key_s.
- Duration counter: one CNT_W counter, cleared on every state change, +1 per cycle, saturates at all-ones.
- IDLE:
  - busy_o=0.
  - key_s=1 -> PRESS; counter starts at 1 on the first high cycle.
- PRESS: counts consecutive key_s=1 cycles (len). On key_s=0:
  - len < GLITCH_CYCLES: discard; return to the prior state (IDLE, or GAP with gap counter restarted at 0); symbols unchanged.
  - GLITCH_CYCLES ≤ len < 2*UNIT_CYCLES: append dot (0).
  - len ≥ 2*UNIT_CYCLES: append dash (1).
  - Append shifts the symbol into the LSB of a 4-bit register and increments the symbol count.
  - If the count is already 4, set the overflow flag instead; the register is unchanged.
  - After an append or overflow, go to GAP with the counter at 1.
- GAP: counts consecutive key_s=0 cycles.
  - key_s=1 before the gap ends -> PRESS (intra-letter gap); symbols kept.
  - When the gap count reaches 3*UNIT_CYCLES, decode, clear symbols and overflow, and go to IDLE.
  - The decode output registers on that edge, so valid_o or error_o is high the following cycle.
- Decode table (first symbol = oldest; dot=., dash=-):
  - A .-  B -...  C -.-.  D -..  E .  F ..-.  G --.  H ....  I ..
  - J .---  K -.-  L .-..  M --  N -.  O ---  P .--.  Q --.-  R .-.
  - S ...  T -  U ..-  V ...-  W .--  X -..-  Y -.--  Z --..
- Decode results:
  - Match, no overflow: letter_o=index, valid_o=1 for one cycle.
  - No match (e.g. ..--, ----, .-.-) or overflow: error_o=1 for one cycle; letter_o unchanged.
  - valid_o and error_o are never both high.
- Key held indefinitely: the counter saturates; the press is classified as a dash on release.
- Reset mid-letter: the partial letter is lost; no strobe is issued.
- Timing (key_i edges synchronous to clk): valid_o/error_o rises exactly 3*UNIT_CYCLES+3 clk edges after the edge at which key_i is first sampled 0 following the final press.

Test Plan (UNIT_CYCLES=10, GLITCH_CYCLES=4):
- Reset, key_i=0 -> all outputs 0, busy_o=0; no strobes over 100 cycles.
- Press 10 cycles, release 10, press 30, release 40 -> exactly one valid_o pulse with letter_o=0 (A), 33 edges after the final release; busy_o=0 afterwards.
- Sequence dash-dot-dot-dot (30/10/10/10 press, 10-cycle gaps), then 40 low -> valid_o, letter_o=1 (B); then single dash -> valid_o, letter_o=19 (T).
- Five dots with 10-cycle gaps, then 40 low -> error_o one cycle, valid_o=0, letter_o keeps its previous value.
- Pattern ..-- -> error_o; a 2-cycle glitch inside a 10-cycle gap of E-then-E -> glitch ignored, gap restarts, then valid_o for E (letter_o=4), then E again.
- Assert rst_n=0 for 1 cycle after two dots mid-letter -> no strobe; the next single dot followed by a gap decodes as E (4), not S.
